ext_stage: RTL and testbench

Registered, parametrised operand-extension stage for the pipelined MIPS datapath, generalising the immediate extender. It handles immediate extension (zero, sign, upper-load) and load-data extension (lb/lbu/lh/lhu/lw lane select) in one unit. Results pass through a single valid/ready pipeline register with stall and flush support. It sits at the MEM/WB boundary, and also serves the ID/EX immediate path. Optionally it flags misaligned loads as AdEL exceptions.

---
 rtl/ext_stage_if.sv | 28 ++
 rtl/ext_stage.sv | 140 ++++++++++++++
 tb/tb_ext_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ext_stage_if.sv
// Request/response bundle for ext_stage: extension request in, registered result out.
interface ext_stage_if #(
    parameter int unsigned IW = 16,
    parameter int unsigned DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    mode;
    logic [IW-1:0] imm;
    logic [31:0]   load_data;
    logic [1:0]    addr_lo;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_exc;
    logic [4:0]    out_exccode;

    modport master (
        output in_valid, mode, imm, load_data, addr_lo, flush, out_ready,
        input  in_ready, out_valid, out_data, out_exc, out_exccode
    );

    modport slave (
        input  in_valid, mode, imm, load_data, addr_lo, flush, out_ready,
        output in_ready, out_valid, out_data, out_exc, out_exccode
    );
endinterface

// File: rtl/ext_stage.sv
// Registered immediate / load-data extension stage with valid/ready, stall and flush.
// Define EXT_ALIGN_CHK_EN to flag misaligned LH/LHU/LW as AdEL (exccode 4).
module ext_stage #(
    parameter int unsigned IW = 16,
    parameter int unsigned DW = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    ext_stage_if.slave  bus
);
    localparam int unsigned EXCW = 5;
    localparam logic [EXCW-1:0] EXC_ADEL = EXCW'(4);

    typedef enum logic [2:0] {
        M_ZERO = 3'd0, M_SIGN = 3'd1, M_HIGH = 3'd2, M_LBU = 3'd3,
        M_LB   = 3'd4, M_LHU  = 3'd5, M_LH   = 3'd6, M_LW  = 3'd7
    } mode_e;

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [DW-1:0] ext_c;
    logic          accept_c;
    mode_e         mode_c;

    assign mode_c = mode_e'(bus.mode);

    // Lane selection for byte and halfword loads
    always_comb begin
        byte_c = bus.load_data[7:0];
        unique case (bus.addr_lo)
            2'd0:    byte_c = bus.load_data[7:0];
            2'd1:    byte_c = bus.load_data[15:8];
            2'd2:    byte_c = bus.load_data[23:16];
            default: byte_c = bus.load_data[31:24];
        endcase
        half_c = bus.addr_lo[1] ? bus.load_data[31:16] : bus.load_data[15:0];
    end

    always_comb begin
        ext_c = '0;
        unique case (mode_c)
            M_ZERO:  ext_c = DW'(bus.imm);
            M_SIGN:  ext_c = DW'($signed(bus.imm));
            M_HIGH:  ext_c = DW'(bus.imm) << (DW - IW);
            M_LBU:   ext_c = DW'(byte_c);
            M_LB:    ext_c = DW'($signed(byte_c));
            M_LHU:   ext_c = DW'(half_c);
            M_LH:    ext_c = DW'($signed(half_c));
            default: ext_c = DW'(bus.load_data);
        endcase
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef EXT_ALIGN_CHK_EN
    logic            misalign_c;
    logic            exc_q, exc_d;
    logic [EXCW-1:0] exccode_q, exccode_d;

    always_comb begin
        misalign_c = 1'b0;
        unique case (mode_c)
            M_LHU, M_LH: misalign_c = bus.addr_lo[0];
            M_LW:        misalign_c = (bus.addr_lo != 2'd0);
            default:     misalign_c = 1'b0;
        endcase
    end

    // Flush beats accept; drain clears valid only, data registers hold
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        exc_d     = exc_q;
        exccode_d = exccode_q;
        if (bus.flush) begin
            valid_d   = 1'b0;
            exc_d     = 1'b0;
            exccode_d = '0;
        end else if (accept_c) begin
            valid_d   = 1'b1;
            data_d    = misalign_c ? '0 : ext_c;
            exc_d     = misalign_c;
            exccode_d = misalign_c ? EXC_ADEL : '0;
        end else if (valid_q && bus.out_ready) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            exc_q     <= 1'b0;
            exccode_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            exc_q     <= exc_d;
            exccode_q <= exccode_d;
        end
    end

    assign bus.out_exc     = exc_q;
    assign bus.out_exccode = exccode_q;
`else
    // Flush beats accept; drain clears valid only, data registers hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d = 1'b1;
            data_d  = ext_c;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.out_exc     = 1'b0;
    assign bus.out_exccode = '0;
`endif

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_ext_stage.sv
// Self-checking bench for ext_stage (IW=16, DW=32): directed cases plus random traffic vs. a reference model.
module tb_ext_stage;
    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    ext_stage_if #(.IW(16), .DW(32)) bus ();

    ext_stage #(.IW(16), .DW(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result of one request: {exc, data}
    function automatic logic [32:0] ref_ext(input logic [2:0] md, input logic [15:0] im,
                                            input logic [31:0] ld, input logic [1:0] a);
        logic [31:0] b, h, d, imm32;
        logic        e;
        imm32 = 32'(im);
        b = (ld >> (8 * int'(a))) & 32'h0000_00FF;
        h = (ld >> (16 * int'(a[1]))) & 32'h0000_FFFF;
        case (md)
            3'd0:    d = imm32;
            3'd1:    d = (imm32 >= 32'd32768) ? imm32 + 32'hFFFF_0000 : imm32;
            3'd2:    d = imm32 * 32'd65536;
            3'd3:    d = b;
            3'd4:    d = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd5:    d = h;
            3'd6:    d = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            default: d = ld;
        endcase
        e = 1'b0;
`ifdef EXT_ALIGN_CHK_EN
        if (((md == 3'd5 || md == 3'd6) && a[0]) || (md == 3'd7 && a != 2'd0)) e = 1'b1;
`endif
        if (e) d = 32'd0;
        return {e, d};
    endfunction

    // Reference state of the output register
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_exc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= 32'd0;
            m_exc   <= 1'b0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
            m_exc   <= 1'b0;
        end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            m_valid <= 1'b1;
            {m_exc, m_data} <= ref_ext(bus.mode, bus.imm, bus.load_data, bus.addr_lo);
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) chk("out_data", bus.out_data, m_data);
        chk("out_exc", 32'(bus.out_exc), 32'(m_exc));
        chk("out_exccode", 32'(bus.out_exccode), m_exc ? 32'd4 : 32'd0);
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge
    task automatic tick(input logic v, input logic [2:0] md, input logic [15:0] im,
                        input logic [31:0] ld, input logic [1:0] a,
                        input logic fl, input logic ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.mode      = md;
        bus.imm       = im;
        bus.load_data = ld;
        bus.addr_lo   = a;
        bus.flush     = fl;
        bus.out_ready = ordy;
        @(negedge clk);
        model_check();
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mode      = 3'd0;
        bus.imm       = 16'd0;
        bus.load_data = 32'd0;
        bus.addr_lo   = 2'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_exc", 32'(bus.out_exc), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Immediate modes back-to-back, then load lanes
        tick(1, 3'd0, 16'h8001, 32'd0, 2'd0, 0, 1);
        tick(1, 3'd1, 16'h8001, 32'd0, 2'd0, 0, 1);
        chk("zero_ext", bus.out_data, 32'h0000_8001);
        tick(1, 3'd2, 16'h8001, 32'd0, 2'd0, 0, 1);
        chk("sign_ext", bus.out_data, 32'hFFFF_8001);
        chk("sign_valid", 32'(bus.out_valid), 32'd1);
        tick(1, 3'd4, 16'h0, 32'h80FF_7F01, 2'd2, 0, 1);
        chk("high_ext", bus.out_data, 32'h8001_0000);
        chk("high_valid", 32'(bus.out_valid), 32'd1);
        tick(1, 3'd3, 16'h0, 32'h80FF_7F01, 2'd3, 0, 1);
        chk("lb_lane2", bus.out_data, 32'hFFFF_FFFF);
        tick(1, 3'd6, 16'h0, 32'h80FF_7F01, 2'd2, 0, 1);
        chk("lbu_lane3", bus.out_data, 32'h0000_0080);
        tick(1, 3'd5, 16'h0, 32'h80FF_7F01, 2'd0, 0, 1);
        chk("lh_hi", bus.out_data, 32'hFFFF_80FF);
        tick(0, 3'd0, 16'h0, 32'd0, 2'd0, 0, 1);
        chk("lhu_lo", bus.out_data, 32'h0000_7F01);

        // Stall for three cycles, then release with no bubble
        tick(1, 3'd7, 16'h0, 32'hA5A5_0001, 2'd0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 3'd7, 16'h0, 32'h2222_2222, 2'd0, 0, 0);
            chk("stall_data", bus.out_data, 32'hA5A5_0001);
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
        end
        tick(1, 3'd7, 16'h0, 32'h2222_2222, 2'd0, 0, 1);
        tick(0, 3'd0, 16'h0, 32'd0, 2'd0, 0, 1);
        chk("unstall_data", bus.out_data, 32'h2222_2222);
        chk("unstall_valid", 32'(bus.out_valid), 32'd1);

        // Flush drops both the held result and the same-cycle input
        tick(1, 3'd7, 16'h0, 32'h1111_1111, 2'd0, 0, 0);
        tick(1, 3'd7, 16'h0, 32'h3333_3333, 2'd0, 1, 1);
        chk("pre_flush_valid", 32'(bus.out_valid), 32'd1);
        tick(0, 3'd0, 16'h0, 32'd0, 2'd0, 0, 1);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        tick(0, 3'd0, 16'h0, 32'd0, 2'd0, 0, 1);
        chk("flush_dropped", 32'(bus.out_valid), 32'd0);

        // Misaligned LW
        tick(1, 3'd7, 16'h0, 32'h1234_5678, 2'd1, 0, 1);
        tick(0, 3'd0, 16'h0, 32'd0, 2'd0, 0, 1);
`ifdef EXT_ALIGN_CHK_EN
        chk("align_exc", 32'(bus.out_exc), 32'd1);
        chk("align_code", 32'(bus.out_exccode), 32'd4);
        chk("align_data", bus.out_data, 32'd0);
`else
        chk("align_exc", 32'(bus.out_exc), 32'd0);
        chk("align_data", bus.out_data, 32'h1234_5678);
`endif

        // Asynchronous reset while stalled
        tick(1, 3'd0, 16'h1234, 32'd0, 2'd0, 0, 0);
        tick(0, 3'd0, 16'h0, 32'd0, 2'd0, 0, 0);
        chk("stalled_valid", 32'(bus.out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", bus.out_data, 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick(logic'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 16'($urandom), 32'($urandom), 2'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
